// File: rtl/gf180mcu_ocd_io_ring_pkg.sv
// Shared types and defaults for the pad-ring output-enable sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf180mcu_ocd_io_ring_pkg;

  localparam int NSEG_DEF  = 4;
  localparam int DWELL_DEF = 16;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_UP   = 3'd1,
    ST_ON   = 3'd2,
    ST_DOWN = 3'd3,
    ST_LOCK = 3'd4
  } ring_state_e;

endpackage

// File: rtl/gf180mcu_ocd_io__ring_dwell_cnt.sv
// Loadable down-counter that times the dwell between segment steps.
// Latency: load/decrement take effect on the next rising edge; zero flag follows the count.
// Backpressure: none; decrement saturates at zero.
module gf180mcu_ocd_io__ring_dwell_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // clear beats load beats decrement; count never wraps below zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gf180mcu_ocd_io__ring_seq.sv
// Steps pad-ring segment output enables on/off one segment per dwell to limit ring switching current.
// Latency: all outputs registered; first enable one edge after EN is sampled high, ABORT clears in one edge.
// Backpressure: none; EN is a level request, reversals are honoured in any cycle.
module gf180mcu_ocd_io__ring_seq
  import gf180mcu_ocd_io_ring_pkg::*;
#(
  parameter int NSEG  = NSEG_DEF,
  parameter int DWELL = DWELL_DEF,
  parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            ABORT,
  output logic [NSEG-1:0] SEG_OE,
  output logic            READY,
  output logic            BUSY
);

  localparam logic [CW-1:0]   RELOAD = CW'(DWELL - 1);
  localparam logic [NSEG-1:0] ONE    = {{(NSEG-1){1'b0}}, 1'b1};

  ring_state_e     state_q, state_d;
  logic [NSEG-1:0] seg_q, seg_d;
  logic [NSEG-1:0] set_mask, clr_mask;
  logic            all_on, any_on;
  logic            cnt_load, cnt_dec, cnt_clr, cnt_zero;

  assign all_on = &seg_q;
  assign any_on = |seg_q;

  // lowest clear bit: scan top-down so the last hit is the lowest
  always_comb begin
    set_mask = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (!seg_q[i]) set_mask = ONE << i;
    end
  end

  // highest set bit: scan bottom-up so the last hit is the highest
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (seg_q[i]) clr_mask = ONE << i;
    end
  end

  // next-state logic: abort first, then EN reversals, then dwell expiry
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (EN) begin
          state_d  = ST_UP;
          seg_d    = seg_q | set_mask;
          cnt_load = 1'b1;
        end
      end
      ST_UP: begin
        if (!EN) begin
          state_d  = ST_DOWN;
          seg_d    = seg_q & ~clr_mask;
          cnt_load = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (!all_on) begin
          seg_d    = seg_q | set_mask;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!EN) begin
          state_d  = ST_DOWN;
          seg_d    = seg_q & ~clr_mask;
          cnt_load = 1'b1;
        end
      end
      ST_DOWN: begin
        if (EN) begin
          state_d  = ST_UP;
          seg_d    = seg_q | set_mask;
          cnt_load = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (any_on) begin
          seg_d    = seg_q & ~clr_mask;
          cnt_load = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_LOCK: begin
        // stay latched off until the requester withdraws EN
        if (!EN) state_d = ST_OFF;
      end
      default: begin
        state_d = ST_OFF;
        seg_d   = '0;
      end
    endcase

    // emergency shutdown drops every segment at once
    if (ABORT && (state_q != ST_LOCK)) begin
      state_d  = ST_LOCK;
      seg_d    = '0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b1;
    end
  end

  // state, thermometer register and registered status flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      seg_q   <= '0;
      READY   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      READY   <= (state_d == ST_ON);
      BUSY    <= (state_d == ST_UP) || (state_d == ST_DOWN);
    end
  end

  assign SEG_OE = seg_q;

  gf180mcu_ocd_io__ring_dwell_cnt #(
    .CW (CW)
  ) u_dwell (
    .clk      (CLK),
    .rst      (RST),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

endmodule

// File: doc/gf180mcu_ocd_io__ring_seq.md
# gf180mcu_ocd_io__ring_seq

Pad-ring output-enable sequencer. Steps output-driver enables on and off, one pad-ring segment at a time, with a programmable dwell between steps. The goal is to limit simultaneous-switching current on the shared ring supplies. Segments are the ring sections bounded by break cells (brk2/brk5), each with its own VSS/VDD rail. The block sits in the core-side IO control logic and drives one enable per segment into the pad cells' output-enable gating.

## Interface
Parameters:
- NSEG, 4, number of ring segments (≥2).
- DWELL, 16, cycles between consecutive segment steps (≥1).
- CW, $clog2(DWELL), dwell counter width (derived; minimum 1).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  block clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- EN  in  1  level request: 1 = ring enabled, 0 = ring disabled.
- ABORT  in  1  emergency shutdown pulse or level (e.g. supply monitor trip).
- SEG_OE  out  NSEG  per-segment output enable; bit 0 is the first segment on and the last off.
- READY  out  1  all segments enabled and settled.
- BUSY  out  1  sequencing in progress (state UP or DOWN).

## Operation
- States: OFF, UP, ON, DOWN, LOCK.
- Reset: state OFF, SEG_OE=0, READY=0, BUSY=0, dwell counter 0.
- Invariant: SEG_OE is always thermometer-coded (bits 0..k set, rest clear). It changes by at most one bit per cycle, except on ABORT.
- OFF, EN=1 → UP. Set SEG_OE[0] and load counter with DWELL-1.
- UP, counter>0 → decrement.
- UP, counter==0:
  - if any segment is off, set the lowest off bit and reload the counter;
  - else → ON with READY=1.
- ON, EN=0 → DOWN. Clear the highest set bit, load counter with DWELL-1, READY=0.
- DOWN, counter==0:
  - if any bit is set, clear the highest set bit and reload;
  - else → OFF.
- UP, EN=0 → DOWN. Clear the highest set bit on the next edge and reload the counter.
- DOWN, EN=1 → UP. Set the lowest clear bit on the next edge and reload the counter.
- Reversal rules apply in any cycle, including mid-dwell.
- ABORT=1 in any state except LOCK → LOCK. On the next edge: SEG_OE=0, READY=0, BUSY=0.
- LOCK → OFF only on the edge after EN is sampled 0. ABORT is ignored while in LOCK.
- Priority: RST > ABORT > EN-driven transitions > dwell countdown.
- BUSY=1 exactly in UP and DOWN. READY=1 exactly in ON.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- EN first sampled 1 at edge t (state OFF). With defaults NSEG=4, DWELL=16:
  - SEG_OE[0] at t+1, [1] at t+1+DWELL (t+17), [2] at t+33, [3] at t+49.
  - READY=1 at t+1+NSEG·DWELL (t+65).
  - BUSY=1 from t+1 to t+64 inclusive.
- EN first sampled 0 at edge u (state ON):
  - READY=0 and SEG_OE[NSEG-1]=0 at u+1.
  - Each lower bit clears DWELL cycles after the previous one; SEG_OE[0]=0 at u+1+(NSEG-1)·DWELL.
  - OFF (BUSY=0) at u+1+NSEG·DWELL.
- DWELL=1: one segment step per cycle.
- ABORT sampled at edge a: outputs all zero at a+1.
- RST mid-sequence: all outputs zero on the next edge with no ramp-down. Reset is the only path besides ABORT that clears multiple bits at once.
- EN toggling faster than DWELL causes repeated reversals. Each reversal moves one segment and restarts the dwell. No state is lost and SEG_OE is never non-thermometer.

## Structure
- Package gf180mcu_ocd_io_ring_pkg holds the state enum (OFF, UP, ON, DOWN, LOCK) and the default NSEG/DWELL localparams.
- Sub-module gf180mcu_ocd_io__ring_dwell_cnt: loadable down-counter with a zero flag, parameterised by CW.
- Top level holds the FSM and the thermometer register. Next bit to set = lowest zero; next bit to clear = highest one. Both are derived from the register by priority logic.

## Test plan
- Power-up, defaults: RST for 2 cycles, then EN=1 held → SEG_OE goes 0001 at t+1, 0011 at t+17, 0111 at t+33, 1111 at t+49; READY=1 at t+65; BUSY high t+1..t+64.
- Power-down from ON: EN=0 at u → SEG_OE goes 0111 at u+1 (READY=0), 0011 at u+17, 0001 at u+33, 0000 at u+49; BUSY=0 at u+65.
- Mid-ramp reversal: EN=0 after SEG_OE reaches 0011 (cycle t+20) → SEG_OE=0001 at t+21, 0000 at t+37, OFF at t+53. Then EN=1 at t+40 during the final dwell → SEG_OE=0001 at t+41.
- ABORT while ON with EN=1 held → SEG_OE=0000, READY=0 next edge. State stays LOCK until EN=0; then OFF; then EN=1 restarts the ramp from 0001.
- RST asserted when SEG_OE=0111 during UP → all outputs 0 next edge; EN=1 after reset release restarts at 0001.
- DWELL=1, NSEG=2 build: EN=1 at t → 01 at t+1, 11 at t+2, READY at t+3. Random EN/ABORT stress checks the thermometer and single-bit-step invariants every cycle.
